// File: rtl/l2_mem_burst_adapter.sv
// l2_mem_burst_adapter: splits one cacheline read/write into a fixed burst of memory beats
module l2_mem_burst_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [ADDR_W-1:0]  line_addr_i,
  input  logic [LINE_W-1:0]  line_wdata_i,
  output logic [LINE_W-1:0]  line_rdata_o,
  output logic               resp_o,
  output logic [ADDR_W-1:0]  burst_addr_o,
  output logic               burst_read_o,
  output logic               burst_write_o,
  output logic [BURST_W-1:0] burst_wdata_o,
  input  logic [BURST_W-1:0] burst_rdata_i,
  input  logic               burst_resp_i,
  output logic               err_o
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [BEATS-1:0][BURST_W-1:0] wline, rline;
  logic busy, last, take;
  assign busy = state == READ || state == WRITE;
  assign last = burst_resp_i && cnt == CW'(BEATS - 1);
  assign take = state == IDLE && (read_i || write_i);
  always_comb begin
    state_nx = state == IDLE ? (read_i ? READ : write_i ? WRITE : IDLE) :
               state == RESP ? IDLE :
               last          ? RESP : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      wline        <= '0;
      rline        <= '0;
      burst_addr_o <= '0;
      err_o        <= 1'b0;
    end else begin
      if (take) burst_addr_o <= line_addr_i & ~ADDR_W'(LINE_W / 8 - 1);
      if (take && !read_i) wline <= line_wdata_i;
      if (busy && burst_resp_i) cnt <= last ? '0 : CW'(cnt + 1'b1);
      if (state == READ && burst_resp_i) rline[cnt] <= burst_rdata_i;
      // beats arriving with no burst outstanding are a memory-side protocol error
      if (!busy && burst_resp_i) err_o <= 1'b1;
    end
  end
  assign line_rdata_o  = rline;
  assign resp_o        = state == RESP;
  assign burst_read_o  = state == READ;
  assign burst_write_o = state == WRITE;
  assign burst_wdata_o = state == WRITE ? wline[cnt] : '0;
endmodule
